// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared geometry constants for the SRAM-backed stream FIFO.
// DW/AW describe the 1024x8 dual-port SRAM behind the controller.
package sram_fifo_ctrl_pkg;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
endpackage

// File: rtl/sram_fifo_ctrl_if.sv
// Upstream (s_*) and downstream (m_*) valid/ready streams.
// slave: the FIFO side; master: the producer/consumer side.
interface sram_fifo_ctrl_if #(
  parameter int DW = sram_fifo_ctrl_pkg::DW
) ();
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/sram_fifo_outbuf.sv
// 2-entry prefetch buffer hiding the SRAM read latency.
// i_cap/i_data: SRAM return; i_pop: head consumed; o_*: head and count.
module sram_fifo_outbuf
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_cap,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_cnt
);
  logic [W-1:0] r_b0;
  logic [W-1:0] r_b1;
  logic [1:0]   r_cnt;

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_b0;
  assign o_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b0  <= '0;
      r_b1  <= '0;
      r_cnt <= 2'd0;
    end else begin
      case ({i_cap, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_b0 <= i_data;
          else               r_b1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_b0  <= r_b1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // count unchanged: new word lands behind the surviving one
          if (r_cnt == 2'd2) begin
            r_b0 <= r_b1;
            r_b1 <= i_data;
          end else begin
            r_b0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// Single-clock FIFO controller over a dual-port SRAM (A writes, B reads).
// Ports: clk, rst_n, bus (streams), fill, sram_* port A/B drive, sram_outb.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int DW = sram_fifo_ctrl_pkg::DW,
  parameter int AW = sram_fifo_ctrl_pkg::AW
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_fifo_ctrl_if.slave   bus,
  output logic [AW+1:0]     fill,
  output logic              sram_ena,
  output logic              sram_wea,
  output logic [AW-1:0]     sram_ada,
  output logic [DW-1:0]     sram_ina,
  output logic              sram_enb,
  output logic              sram_web,
  output logic [AW-1:0]     sram_adb,
  input  logic [DW-1:0]     sram_outb
);
  localparam logic [AW:0] LP_FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_sram_cnt;
  logic          r_inflight;
  logic [AW+1:0] r_fill;

  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic [1:0]    w_buf_cnt;
  logic [2:0]    w_occ;
  logic [2:0]    w_lim;
  logic [2:0]    w_buf_nxt;
  logic [AW:0]   w_cnt_nxt;
  logic [AW+1:0] w_fill_nxt;

  assign bus.s_ready = (r_sram_cnt != LP_FULL);
  // rst_n gate keeps both SRAM ports quiet while reset is held
  assign w_push = bus.s_valid & bus.s_ready & rst_n;
  assign w_pop  = bus.m_valid & bus.m_ready;

  // buffer slots already claimed (held + returning), minus this pop
  assign w_occ     = {1'b0, w_buf_cnt} + {2'b00, r_inflight};
  assign w_lim     = 3'd2 + {2'b00, w_pop};
  assign w_issue   = (r_sram_cnt != '0) & (w_occ < w_lim);
  assign w_buf_nxt = w_occ - {2'b00, w_pop};

  assign w_cnt_nxt = r_sram_cnt
                   + {{AW{1'b0}}, w_push}
                   - {{AW{1'b0}}, w_issue};
  assign w_fill_nxt = {1'b0, w_cnt_nxt}
                    + {{(AW+1){1'b0}}, w_issue}
                    + {{(AW-1){1'b0}}, w_buf_nxt};

  assign sram_ena = w_push;
  assign sram_wea = w_push;
  assign sram_ada = r_wr_ptr;
  assign sram_ina = bus.s_data;
  assign sram_enb = w_issue;
  assign sram_web = 1'b0;
  assign sram_adb = r_rd_ptr;
  assign fill     = r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sram_cnt <= '0;
      r_inflight <= 1'b0;
      r_fill     <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_sram_cnt <= w_cnt_nxt;
      r_inflight <= w_issue;
      r_fill     <= w_fill_nxt;
    end
  end

  sram_fifo_outbuf #(.W(DW)) u_outbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_cap   (r_inflight),
    .i_data  (sram_outb),
    .i_pop   (w_pop),
    .o_valid (bus.m_valid),
    .o_data  (bus.m_data),
    .o_cnt   (w_buf_cnt)
  );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench: queue scoreboard plus SRAM model and directed cases.
// Covers latency, stall/full, throughput, random traffic, async reset.
module tb_sram_fifo_ctrl;
  import sram_fifo_ctrl_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW+1:0] fill;
  logic          sram_ena, sram_wea, sram_enb, sram_web;
  logic [AW-1:0] sram_ada, sram_adb;
  logic [DW-1:0] sram_ina, sram_outb;

  sram_fifo_ctrl_if #(.DW(DW)) bus ();

  sram_fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fill      (fill),
    .sram_ena  (sram_ena),
    .sram_wea  (sram_wea),
    .sram_ada  (sram_ada),
    .sram_ina  (sram_ina),
    .sram_enb  (sram_enb),
    .sram_web  (sram_web),
    .sram_adb  (sram_adb),
    .sram_outb (sram_outb)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_ena && sram_wea) mem[sram_ada] <= sram_ina;
    if (sram_enb) sram_outb <= mem[sram_adb];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    int         t;
  } ent_t;

  ent_t       q[$];
  int         cyc = 0;
  int         n_push = 0;
  int         n_pop = 0;
  int         first_pop = -1;
  int         last_pop_cyc = 0;
  logic [7:0] last_pop = 8'h00;
  logic       stall_d = 1'b0;
  logic [7:0] data_d = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      stall_d = 1'b0;
    end else begin
      ent_t e;
      cyc++;
      stall_d = bus.m_valid && !bus.m_ready;
      data_d  = bus.m_data;
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() > 0) begin
          last_pop = q[0].d;
          void'(q.pop_front());
        end
        n_pop++;
        if (first_pop < 0) first_pop = cyc;
        last_pop_cyc = cyc;
      end
      if (bus.s_valid && bus.s_ready) begin
        e.d = bus.s_data;
        e.t = cyc;
        q.push_back(e);
        n_push++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("fill", 32'(fill), 32'(q.size()));
      chk("valid_nonempty", 32'(bus.m_valid && q.size() == 0), 0);
      if (bus.m_valid && q.size() > 0)
        chk("m_data", 32'(bus.m_data), 32'(q[0].d));
      if (q.size() > 0 && q[0].t + 2 <= cyc)
        chk("m_valid_lat", 32'(bus.m_valid), 1);
      if (q.size() <= DEPTH)
        chk("s_ready_open", 32'(bus.s_ready), 1);
      if (q.size() >= DEPTH + 2)
        chk("s_ready_full", 32'(bus.s_ready), 0);
      if (stall_d) begin
        chk("stall_valid", 32'(bus.m_valid), 1);
        chk("stall_data", 32'(bus.m_data), 32'(data_d));
      end
      chk("web", 32'(sram_web), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    while (fill != 0 && n < 3000) begin
      step();
      n++;
    end
    chk(nm, 32'(fill), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int p0;
    int c0;
    int n;
    rst_n = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 8'h3C;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 1);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_ena", 32'(sram_ena), 0);
    chk("rst_enb", 32'(sram_enb), 0);
    bus.s_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // three words, open downstream
    bus.s_valid = 1'b1;
    bus.s_data = 8'h11;
    bus.m_ready = 1'b1;
    step();
    bus.s_data = 8'h22;
    chk("lat_n", 32'(bus.m_valid), 0);
    step();
    bus.s_data = 8'h33;
    chk("lat_n1", 32'(bus.m_valid), 0);
    step();
    bus.s_valid = 1'b0;
    chk("lat_n2_v", 32'(bus.m_valid), 1);
    chk("out0", 32'(bus.m_data), 32'h11);
    step();
    chk("out1_v", 32'(bus.m_valid), 1);
    chk("out1", 32'(bus.m_data), 32'h22);
    step();
    chk("out2_v", 32'(bus.m_valid), 1);
    chk("out2", 32'(bus.m_data), 32'h33);
    step();
    chk("out_done_v", 32'(bus.m_valid), 0);
    chk("out_done_fill", 32'(fill), 0);

    // stall until full
    bus.m_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 1100; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data = acc[7:0];
      if (bus.s_ready) acc++;
      step();
    end
    bus.s_valid = 1'b0;
    chk("full_accepted", 32'(acc), 1026);
    chk("full_fill", 32'(fill), 1026);
    chk("full_s_ready", 32'(bus.s_ready), 0);

    // one-cycle pop while full
    p0 = n_pop;
    bus.m_ready = 1'b1;
    chk("pulse_s_ready_pre", 32'(bus.s_ready), 0);
    chk("pulse_head", 32'(bus.m_data), 32'h00);
    step();
    bus.m_ready = 1'b0;
    chk("pulse_s_ready_post", 32'(bus.s_ready), 1);
    chk("pulse_fill", 32'(fill), 1025);
    bus.s_valid = 1'b1;
    bus.s_data = 8'hEE;
    step();
    bus.s_valid = 1'b0;
    chk("refull_fill", 32'(fill), 1026);
    chk("refull_s_ready", 32'(bus.s_ready), 0);
    drain("drain_full");
    chk("drain_full_cnt", 32'(n_pop - p0), 1027);
    chk("drain_full_last", 32'(last_pop), 32'hEE);

    // continuous 1 word/clk
    step();
    p0 = n_pop;
    c0 = n_push;
    first_pop = -1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'(i) ^ 8'h5A;
      step();
    end
    drain("drain_stream");
    chk("stream_push", 32'(n_push - c0), 3000);
    chk("stream_pop", 32'(n_pop - p0), 3000);
    chk("stream_nobubble", 32'(last_pop_cyc - first_pop), 2999);
    chk("stream_last", 32'(last_pop), 32'((2999 & 255) ^ 8'h5A));

    // random traffic
    c0 = n_push;
    n = 0;
    while (n_push - c0 < 10000 && n < 60000) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data = 8'($urandom);
      bus.m_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk("rand_pushed", 32'(n_push - c0 >= 10000), 1);
    drain("drain_rand");

    // reset with 500 words held
    bus.m_ready = 1'b0;
    for (int i = 0; i < 500; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data = 8'(i);
      step();
    end
    bus.s_valid = 1'b0;
    step();
    chk("pre_rst_fill", 32'(fill), 500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(bus.m_valid), 0);
    chk("mid_rst_fill", 32'(fill), 0);
    chk("mid_rst_s_ready", 32'(bus.s_ready), 1);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step();
    bus.s_valid = 1'b1;
    bus.s_data = 8'hA5;
    bus.m_ready = 1'b1;
    step();
    bus.s_valid = 1'b0;
    n = 0;
    while (!bus.m_valid && n < 8) begin
      step();
      n++;
    end
    chk("post_rst_valid", 32'(bus.m_valid), 1);
    chk("post_rst_first", 32'(bus.m_data), 32'hA5);
    drain("drain_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
